i3c_dat_arbiter: RTL and testbench

Two-port arbiter between the Device Address Table (DAT) RAM and its two users: the CSR path (32-bit host word accesses) and the controller command engine (64-bit entry reads). Sits directly upstream of the DAT single-port RAM. It drives the RAM request/write/addr/wdata/wmask bundle and routes the 1-cycle-latency read data back to the issuing port. Fair alternation under contention; single-cycle grant when uncontended.

---
 rtl/i3c_dat_arbiter.sv | 91 +++++++++
 tb/tb_i3c_dat_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i3c_dat_arbiter.sv
// i3c_dat_arbiter: shares the DAT single-port RAM between the CSR word path
// and the controller entry-read path, alternating under contention.
module i3c_dat_arbiter #(
  parameter int Depth = 128,
  parameter int AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             csr_req_i,
  output logic             csr_gnt_o,
  input  logic             csr_write_i,
  input  logic [AddrW:0]   csr_addr_i,
  input  logic [31:0]      csr_wdata_i,
  output logic             csr_rvalid_o,
  output logic [31:0]      csr_rdata_o,

  input  logic             ctrl_req_i,
  output logic             ctrl_gnt_o,
  input  logic [AddrW-1:0] ctrl_addr_i,
  output logic             ctrl_rvalid_o,
  output logic [63:0]      ctrl_rdata_o,

  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [63:0]      mem_wdata_o,
  output logic [63:0]      mem_wmask_o,
  input  logic [63:0]      mem_rdata_i
);

  logic last_ctrl;
  logic rd_csr;
  logic rd_ctrl;
  logic half_q;
  logic csr_rd_gnt;

  // Grants are held off during reset so every output reads zero.
  assign csr_gnt_o  = ~rst_i & csr_req_i
                    & (~ctrl_req_i | last_ctrl);
  assign ctrl_gnt_o = ~rst_i & ctrl_req_i
                    & (~csr_req_i | ~last_ctrl);
  assign mem_req_o  = csr_gnt_o | ctrl_gnt_o;
  assign csr_rd_gnt = csr_gnt_o & ~csr_write_i;

  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    unique case (1'b1)
      csr_gnt_o: begin
        mem_write_o = csr_write_i;
        mem_addr_o  = csr_addr_i[AddrW:1];
        if (csr_write_i) begin
          mem_wdata_o = {csr_wdata_i, csr_wdata_i};
          mem_wmask_o = csr_addr_i[0]
                      ? {32'hFFFF_FFFF, 32'h0}
                      : {32'h0, 32'hFFFF_FFFF};
        end
      end
      ctrl_gnt_o: begin
        mem_addr_o = ctrl_addr_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_ctrl <= 1'b1;
      rd_csr    <= 1'b0;
      rd_ctrl   <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      if (mem_req_o) last_ctrl <= ctrl_gnt_o;
      rd_csr  <= csr_rd_gnt;
      rd_ctrl <= ctrl_gnt_o;
      if (csr_rd_gnt) half_q <= csr_addr_i[0];
    end
  end

  assign csr_rvalid_o  = rd_csr;
  assign ctrl_rvalid_o = rd_ctrl;

  assign csr_rdata_o  = !rd_csr ? 32'h0
                      : half_q ? mem_rdata_i[63:32]
                      : mem_rdata_i[31:0];
  assign ctrl_rdata_o = rd_ctrl ? mem_rdata_i : 64'h0;

endmodule

// File: tb/tb_i3c_dat_arbiter.sv
// tb_i3c_dat_arbiter: directed checks of arbitration, write masking,
// read return routing and async reset of the DAT arbiter.
module tb_i3c_dat_arbiter;
  localparam int Depth = 128;
  localparam int AW = 7;

  logic          clk;
  logic          rst;
  logic          csr_req;
  logic          csr_gnt;
  logic          csr_write;
  logic [AW:0]   csr_addr;
  logic [31:0]   csr_wdata;
  logic          csr_rvalid;
  logic [31:0]   csr_rdata;
  logic          ctrl_req;
  logic          ctrl_gnt;
  logic [AW-1:0] ctrl_addr;
  logic          ctrl_rvalid;
  logic [63:0]   ctrl_rdata;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_wmask;
  logic [63:0]   mem_rdata;

  int total = 0;
  int bad = 0;

  logic [63:0] ram [Depth];

  i3c_dat_arbiter #(.Depth(Depth)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .csr_req_i    (csr_req),
    .csr_gnt_o    (csr_gnt),
    .csr_write_i  (csr_write),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_rvalid_o (csr_rvalid),
    .csr_rdata_o  (csr_rdata),
    .ctrl_req_i   (ctrl_req),
    .ctrl_gnt_o   (ctrl_gnt),
    .ctrl_addr_i  (ctrl_addr),
    .ctrl_rvalid_o(ctrl_rvalid),
    .ctrl_rdata_o (ctrl_rdata),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wmask_o  (mem_wmask),
    .mem_rdata_i  (mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with 1-cycle read latency and bit-masked writes.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_write)
        ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask)
                       | (mem_wdata & mem_wmask);
      else
        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [AW:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    csr_req = 1; csr_write = 1; csr_addr = a; csr_wdata = d;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = csr_gnt;
      tick();
    end
    csr_req = 0; csr_write = 0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL csr_wr_timeout addr=%0d got no grant", a);
    end
  endtask

  task automatic test_reset();
    rst = 1; csr_req = 1; ctrl_req = 1;
    csr_write = 0; csr_addr = 0; csr_wdata = 0; ctrl_addr = 0;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({csr_gnt, ctrl_gnt, mem_req, mem_write, csr_rvalid, ctrl_rvalid} !== 6'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=000000", {csr_gnt, ctrl_gnt, mem_req, mem_write, csr_rvalid, ctrl_rvalid});
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wmask, csr_rdata, ctrl_rdata} !== '0) begin
      bad++;
      $display("FAIL rst_data got addr=%h wd=%h wm=%h cd=%h kd=%h exp=0", mem_addr, mem_wdata, mem_wmask, csr_rdata, ctrl_rdata);
    end
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if ({csr_gnt, ctrl_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL rst_first_gnt got=%b exp=10", {csr_gnt, ctrl_gnt});
    end
    tick();
    @(negedge clk);
    total++;
    if ({csr_gnt, ctrl_gnt, csr_rvalid} !== 3'b011) begin
      bad++;
      $display("FAIL rst_second_gnt got=%b exp=011", {csr_gnt, ctrl_gnt, csr_rvalid});
    end
    tick();
    csr_req = 0; ctrl_req = 0;
    @(negedge clk);
    total++;
    if ({ctrl_rvalid, csr_rvalid, mem_req} !== 3'b100) begin
      bad++;
      $display("FAIL rst_ctrl_rvalid got=%b exp=100", {ctrl_rvalid, csr_rvalid, mem_req});
    end
    tick();
  endtask

  task automatic test_csr_write_read();
    csr_req = 1; csr_write = 1; csr_addr = 10; csr_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({csr_gnt, mem_req, mem_write} !== 3'b111 || mem_addr !== 7'd5) begin
      bad++;
      $display("FAIL wr_lo_ctl got=%b addr=%0d exp=111 addr=5", {csr_gnt, mem_req, mem_write}, mem_addr);
    end
    total++;
    if (mem_wmask !== 64'h00000000_FFFFFFFF || mem_wdata !== 64'hDEADBEEF_DEADBEEF) begin
      bad++;
      $display("FAIL wr_lo_mask got wm=%h wd=%h exp wm=00000000ffffffff wd=deadbeefdeadbeef", mem_wmask, mem_wdata);
    end
    tick();
    csr_addr = 11; csr_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (csr_rvalid !== 1'b0 || mem_wmask !== 64'hFFFFFFFF_00000000) begin
      bad++;
      $display("FAIL wr_hi got rv=%b wm=%h exp rv=0 wm=ffffffff00000000", csr_rvalid, mem_wmask);
    end
    tick();
    csr_write = 0; csr_addr = 11;
    @(negedge clk);
    total++;
    if ({csr_gnt, mem_write} !== 2'b10 || mem_wmask !== 64'h0 || mem_addr !== 7'd5) begin
      bad++;
      $display("FAIL rd_hi_req got=%b wm=%h addr=%0d exp=10 wm=0 addr=5", {csr_gnt, mem_write}, mem_wmask, mem_addr);
    end
    tick();
    csr_addr = 10;
    @(negedge clk);
    total++;
    if (csr_rvalid !== 1'b1 || csr_rdata !== 32'h12345678) begin
      bad++;
      $display("FAIL rd_hi_data got rv=%b d=%h exp rv=1 d=12345678", csr_rvalid, csr_rdata);
    end
    tick();
    csr_req = 0;
    @(negedge clk);
    total++;
    if (csr_rvalid !== 1'b1 || csr_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rd_lo_data got rv=%b d=%h exp rv=1 d=deadbeef", csr_rvalid, csr_rdata);
    end
    tick();
    @(negedge clk);
    total++;
    if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rd_idle got rv=%b d=%h exp rv=0 d=0", csr_rvalid, csr_rdata);
    end
    tick();
  endtask

  task automatic test_ctrl_read();
    csr_wr(6, 32'h0000_5A5A);
    csr_wr(7, 32'hA5A5_0000);
    ctrl_req = 1; ctrl_addr = 3;
    @(negedge clk);
    total++;
    if ({ctrl_gnt, csr_gnt, mem_write} !== 3'b100 || mem_addr !== 7'd3) begin
      bad++;
      $display("FAIL ctrl_gnt got=%b addr=%0d exp=100 addr=3", {ctrl_gnt, csr_gnt, mem_write}, mem_addr);
    end
    tick();
    ctrl_req = 0;
    @(negedge clk);
    total++;
    if (ctrl_rvalid !== 1'b1 || ctrl_rdata !== 64'hA5A5_0000_0000_5A5A || csr_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL ctrl_data got rv=%b d=%h crv=%b exp rv=1 d=a5a5000000005a5a crv=0", ctrl_rvalid, ctrl_rdata, csr_rvalid);
    end
    tick();
    @(negedge clk);
    total++;
    if (ctrl_rvalid !== 1'b0 || ctrl_rdata !== 64'h0) begin
      bad++;
      $display("FAIL ctrl_once got rv=%b d=%h exp rv=0 d=0", ctrl_rvalid, ctrl_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    csr_req = 1; csr_write = 0; csr_addr = 10;
    ctrl_req = 1; ctrl_addr = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if ({csr_gnt, ctrl_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, {csr_gnt, ctrl_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        total++;
        if ((i % 2 == 1) ? (csr_rvalid !== 1'b1 || csr_rdata !== 32'hDEADBEEF || ctrl_rvalid !== 1'b0)
                         : (ctrl_rvalid !== 1'b1 || ctrl_rdata !== 64'hA5A5_0000_0000_5A5A || csr_rvalid !== 1'b0)) begin
          bad++;
          $display("FAIL cont_ret[%0d] got crv=%b cd=%h krv=%b kd=%h", i, csr_rvalid, csr_rdata, ctrl_rvalid, ctrl_rdata);
        end
      end
      tick();
    end
    csr_req = 0; ctrl_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int grants;
    grants = 0;
    for (int e = 0; e < 8; e++) begin
      csr_wr(AW'(2 * e) + 8'd0, 32'h1000_0000 + e);
      csr_wr(AW'(2 * e) + 8'd1, 32'hC0DE_0000 + e);
    end
    ctrl_req = 1;
    for (int i = 0; i <= 8; i++) begin
      ctrl_addr = AW'(i);
      if (i == 8) ctrl_req = 0;
      @(negedge clk);
      if (ctrl_gnt) grants++;
      if (i > 0) begin
        total++;
        if (ctrl_rvalid !== 1'b1 || ctrl_rdata !== {32'hC0DE_0000 + 32'(i - 1), 32'h1000_0000 + 32'(i - 1)}) begin
          bad++;
          $display("FAIL stream[%0d] got rv=%b d=%h exp rv=1 d=%h", i - 1, ctrl_rvalid, ctrl_rdata, {32'hC0DE_0000 + 32'(i - 1), 32'h1000_0000 + 32'(i - 1)});
        end
      end
      tick();
    end
    total++;
    if (grants != 8) begin
      bad++;
      $display("FAIL stream_grants got=%0d exp=8", grants);
    end
    @(negedge clk);
    total++;
    if (ctrl_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL stream_end got rv=%b exp rv=0", ctrl_rvalid);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    csr_req = 1; csr_write = 0; csr_addr = 10;
    @(negedge clk);
    total++;
    if (csr_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mrst_gnt got=%b exp=1", csr_gnt);
    end
    tick();
    csr_req = 0;
    #1;
    total++;
    if (csr_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL mrst_pre got rv=%b exp rv=1", csr_rvalid);
    end
    rst = 1;
    #1;
    total++;
    if (csr_rvalid !== 1'b0 || csr_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mrst_async got rv=%b d=%h exp rv=0 d=0", csr_rvalid, csr_rdata);
    end
    tick();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (csr_rvalid !== 1'b0 || ctrl_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL mrst_stale[%0d] got crv=%b krv=%b exp 0 0", i, csr_rvalid, ctrl_rvalid);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1; csr_req = 0; ctrl_req = 0; csr_write = 0;
    csr_addr = 0; csr_wdata = 0; ctrl_addr = 0;
    test_reset();
    test_csr_write_read();
    test_ctrl_read();
    test_contention();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
